// File: rtl/fmap_streamer.sv
// fmap_streamer: streams one feature-map channel from a synchronous-read memory
// in raster order, optionally surrounded by a one-pixel zero border.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   start                 one-cycle request; input_dim/pad/base_addr sampled with it
//   input_dim, pad        side length N (3..224) and zero-border enable
//   base_addr             address of pixel (0,0)
//   mem_rd_en, mem_addr   read request to the memory (registered)
//   mem_rdata             read data, valid one cycle after mem_rd_en
//   out_data, out_valid   pixel stream toward the window generator
//   out_ready             downstream accept
//   busy, done            stream in progress / one-cycle completion pulse (registered)
module fmap_streamer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            input_dim,
   input  logic                  pad,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DIM_W = 8;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned TOT_W = 3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state, state_nxt;

   logic [DIM_W-1:0]      dim_q;
   logic                  pad_q;
   logic [DIM_W-1:0]      row, col;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  last_issued;

   // Two-stage issue pipe: s1 = request cycle, s2 = data cycle (mem_rdata or zero).
   logic                  s1_valid, s1_zero;
   logic                  s2_valid, s2_zero;

   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  head;
   logic [CNT_W-1:0]      count;

   logic [DIM_W-1:0]      side;
   logic                  at_last_col, at_last_row, border;
   logic [DATA_WIDTH-1:0] s2_data;
   logic                  pop, fifo_pop, push;
   logic [CNT_W-1:0]      count_nxt;
   logic                  final_xfer;
   logic                  accept, issue;

   // Geometry of the current pixel
   assign side        = pad_q ? dim_q + DIM_W'(2) : dim_q;
   assign at_last_col = (col == side - DIM_W'(1));
   assign at_last_row = (row == side - DIM_W'(1));
   assign border      = pad_q && ((row == '0) || (col == '0) || at_last_row || at_last_col);

   // The arriving pixel bypasses the FIFO when it is empty, so the first pixel
   // is visible in the same cycle its read data returns.
   assign s2_data   = s2_zero ? '0 : mem_rdata;
   assign out_valid = (count != '0) || s2_valid;
   assign out_data  = (count != '0) ? fifo_mem[head] : (s2_valid ? s2_data : '0);

   assign pop       = out_valid && out_ready;
   assign fifo_pop  = pop && (count != '0);
   assign push      = s2_valid && !(pop && (count == '0));
   assign count_nxt = count + CNT_W'(push) - CNT_W'(fifo_pop);

   // Last pixel leaves when nothing else is queued or in flight
   assign final_xfer = (state == DRAIN) && pop &&
                       ((TOT_W'(count) + TOT_W'(s1_valid) + TOT_W'(s2_valid)) == TOT_W'(1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and issue control; issue only while FIFO plus in-flight stays below 2
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_issued) state_nxt = DRAIN;
            else if ((TOT_W'(count_nxt) + TOT_W'(s1_valid)) < TOT_W'(2)) issue = 1'b1;
         end
         DRAIN: begin
            if (final_xfer) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: parameter latch, raster counters, read issue, FIFO, status
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dim_q       <= '0;
         pad_q       <= 1'b0;
         row         <= '0;
         col         <= '0;
         next_addr   <= '0;
         last_issued <= 1'b0;
         s1_valid    <= 1'b0;
         s1_zero     <= 1'b0;
         s2_valid    <= 1'b0;
         s2_zero     <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         head        <= 1'b0;
         count       <= '0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         mem_rd_en <= 1'b0;
         done      <= final_xfer;
         s2_valid  <= s1_valid;
         s2_zero   <= s1_zero;
         s1_valid  <= 1'b0;
         s1_zero   <= 1'b0;

         // Occupancy never exceeds 2, so a push never meets a full FIFO
         if (push) fifo_mem[head ^ count[0]] <= s2_data;
         if (fifo_pop) head <= ~head;
         count <= count_nxt;

         if (accept) begin
            // Pixel (0,0) is issued on the accepting edge itself
            dim_q       <= input_dim;
            pad_q       <= pad;
            busy        <= 1'b1;
            last_issued <= 1'b0;
            row         <= '0;
            col         <= DIM_W'(1);
            s1_valid    <= 1'b1;
            s1_zero     <= pad;
            mem_rd_en   <= !pad;
            mem_addr    <= base_addr;
            next_addr   <= pad ? base_addr : base_addr + ADDR_WIDTH'(1);
         end else if (issue) begin
            s1_valid <= 1'b1;
            s1_zero  <= border;
            // Interior pixels are contiguous in memory in raster order
            if (!border) begin
               mem_rd_en <= 1'b1;
               mem_addr  <= next_addr;
               next_addr <= next_addr + ADDR_WIDTH'(1);
            end
            if (at_last_col) begin
               col <= '0;
               row <= row + DIM_W'(1);
               if (at_last_row) last_issued <= 1'b1;
            end else begin
               col <= col + DIM_W'(1);
            end
         end

         if (final_xfer) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fmap_streamer.sv
// tb_fmap_streamer: directed self-checking bench for fmap_streamer with a
// synchronous-read memory model whose content is mem[a] = a[7:0].
module tb_fmap_streamer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  input_dim;
   logic        pad;
   logic [15:0] base_addr;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   logic [7:0]  rx_q[$];
   logic [15:0] addr_q[$];
   int          first_valid_cyc, xfer_cyc_last, done_cyc, done_cnt, stall_err;
   logic        done_busy;
   int          s;

   fmap_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .input_dim (input_dim),
      .pad       (pad),
      .base_addr (base_addr),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous-read memory; also logs every requested address
   always @(posedge clock) begin
      if (mem_rd_en) begin
         mem_rdata <= mem_addr[7:0];
         addr_q.push_back(mem_addr);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"},  32'(out_data),  32'd0);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      check({tag, "_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
   endtask

   // Drives start during cycle S, returns at #1 after the negedge of cycle S+1
   task automatic do_start(input logic [7:0] n, input logic p, input logic [15:0] b, output int s_cyc);
      @(negedge clock);
      input_dim = n;
      pad       = p;
      base_addr = b;
      start     = 1'b1;
      s_cyc     = cyc;
      @(negedge clock);
      start = 1'b0;
      #1;
   endtask

   // Receives the stream; optional random stalls, a stray start after
   // restart_at transfers, or an early exit after abort_at transfers.
   task automatic collect(input int budget, input bit rnd, input int restart_at, input int abort_at);
      logic [7:0] pd;
      bit         pstall, fin;
      int         tail;
      rx_q.delete();
      first_valid_cyc = -1;
      xfer_cyc_last   = -1;
      done_cyc        = -1;
      done_cnt        = 0;
      stall_err       = 0;
      done_busy       = 1'bx;
      pstall          = 1'b0;
      fin             = 1'b0;
      tail            = 0;
      pd              = 8'h00;
      for (int i = 0; i < budget && !fin; i++) begin
         @(negedge clock);
         if (start) start = 1'b0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (pstall && (!out_valid || out_data !== pd)) stall_err++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc  = cyc;
               done_busy = busy;
            end
         end
         pstall = out_valid && !out_ready;
         pd     = out_data;
         if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            xfer_cyc_last = cyc;
            if (rx_q.size() == restart_at) begin
               input_dim = 8'd3;
               pad       = 1'b1;
               base_addr = 16'h0000;
               start     = 1'b1;
            end
            if (rx_q.size() == abort_at) fin = 1'b1;
         end
         if (done_cyc >= 0) begin
            tail++;
            if (tail > 4) fin = 1'b1;
         end
      end
      check("collect_in_budget", 32'(fin), 32'd1);
      out_ready = 1'b1;
   endtask

   // Reference raster model: border zero, interior = base + r'*N + c' (mod 2^16)
   task automatic check_stream(input string tag, input int n, input bit p, input logic [15:0] b);
      int          m, k;
      logic [15:0] a;
      logic [7:0]  e;
      m = p ? n + 2 : n;
      k = 0;
      check({tag, "_len"}, 32'(rx_q.size()), 32'(m * m));
      for (int r = 0; r < m; r++) begin
         for (int c = 0; c < m; c++) begin
            if (p && (r == 0 || c == 0 || r == m - 1 || c == m - 1)) begin
               e = 8'h00;
            end else begin
               a = b + 16'((p ? r - 1 : r) * n + (p ? c - 1 : c));
               e = a[7:0];
            end
            if (k < rx_q.size()) check($sformatf("%s_px%0d", tag, k), 32'(rx_q[k]), 32'(e));
            k++;
         end
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done_cnt"},  32'(done_cnt),  32'd1);
      check({tag, "_done_time"}, 32'(done_cyc),  32'(xfer_cyc_last + 1));
      check({tag, "_busy_done"}, 32'(done_busy), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      input_dim = 8'd0;
      pad       = 1'b0;
      base_addr = 16'h0000;
      out_ready = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b0;

      // A: N=7, no pad, latency and full-rate stream
      do_start(8'd7, 1'b0, 16'h0100, s);
      check("A_rd_en_s1", 32'(mem_rd_en), 32'd1);
      check("A_addr_s1",  32'(mem_addr),  32'h0100);
      check("A_valid_s1", 32'(out_valid), 32'd0);
      check("A_busy_s1",  32'(busy),      32'd1);
      collect(400, 1'b0, -1, -1);
      check("A_first_valid_lat", 32'(first_valid_cyc - s), 32'd2);
      check("A_rate", 32'(xfer_cyc_last - first_valid_cyc), 32'd48);
      check_stream("A", 7, 1'b0, 16'h0100);
      check_done("A");

      // B: N=7 with zero border
      do_start(8'd7, 1'b1, 16'h0105, s);
      collect(400, 1'b0, -1, -1);
      check_stream("B", 7, 1'b1, 16'h0105);
      check("B_px_1_1", 32'(rx_q.size() > 10 ? rx_q[10] : 8'hxx), 32'h05);
      check_done("B");

      // C: N=14 with random backpressure
      do_start(8'd14, 1'b0, 16'h0200, s);
      collect(2000, 1'b1, -1, -1);
      check_stream("C", 14, 1'b0, 16'h0200);
      check("C_stall_stable", 32'(stall_err), 32'd0);
      check_done("C");

      // D: address wrap at the top of the address space
      addr_q.delete();
      do_start(8'd3, 1'b0, 16'hFFFE, s);
      collect(200, 1'b0, -1, -1);
      check("D_n_addr", 32'(addr_q.size()), 32'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < addr_q.size()) check($sformatf("D_addr%0d", i), 32'(addr_q[i]), 32'(16'(16'hFFFE + 16'(i))));
      end
      check_stream("D", 3, 1'b0, 16'hFFFE);
      check_done("D");

      // E: stray start mid-stream is ignored
      do_start(8'd7, 1'b0, 16'h0100, s);
      collect(400, 1'b0, 10, -1);
      check_stream("E", 7, 1'b0, 16'h0100);
      check_done("E");

      // F: reset after the 20th transfer, then a fresh stream
      do_start(8'd7, 1'b0, 16'h0100, s);
      collect(400, 1'b0, -1, 20);
      check("F_pre_abort_len", 32'(rx_q.size()), 32'd20);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_idle_outputs("F_abort");
      @(negedge clock);
      reset = 1'b0;
      do_start(8'd7, 1'b0, 16'h0100, s);
      check("F2_addr_s1", 32'(mem_addr), 32'h0100);
      collect(400, 1'b0, -1, -1);
      check_stream("F2", 7, 1'b0, 16'h0100);
      check_done("F2");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
